// File: rtl/ula_arbiter_ctrl.sv
// rtl/ula_arbiter_ctrl.sv - two-requester arbiter and sequencer for a shared 8-bit ULA
//
// Purpose:
//   Grants one of two requesters access to a combinational ULA and holds the
//   registered operands on the ULA inputs for EXEC_CYCLES cycles. It then
//   captures OUT/CARRY and presents them as a response until the response
//   is accepted.
// Parameters:
//   EXEC_CYCLES  cycles the ULA inputs are held before capture (1..15)
//   PRIO_FIXED   0 = round-robin, 1 = requester 0 always wins a tie
// Optional feature macro:
//   ULA_ARB_STATS_EN  enables the saturating OP_COUNT counter; otherwise OP_COUNT = 0
// Ports:
//   CLK, RST_N                     clock (rising edge), async active-low reset
//   REQ_VALID/REQ_READY            per-requester handshake, bit i = requester i
//   REQ_A/REQ_B/REQ_COND           operands and op select, {req1, req0}
//   ULA_A/ULA_B/ULA_COND           registered drive to the ULA
//   ULA_OUT/ULA_CARRY              ULA result inputs
//   RSP_VALID/RSP_READY            response handshake
//   RSP_ID/RSP_DATA/RSP_CARRY      captured response
//   OP_COUNT                       completed-operation count

module ula_arbiter_ctrl #(
  parameter int EXEC_CYCLES = 1,
  parameter bit PRIO_FIXED  = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [1:0]  REQ_VALID,
  output logic [1:0]  REQ_READY,
  input  logic [15:0] REQ_A,
  input  logic [15:0] REQ_B,
  input  logic [3:0]  REQ_COND,
  output logic [7:0]  ULA_A,
  output logic [7:0]  ULA_B,
  output logic [1:0]  ULA_COND,
  input  logic [7:0]  ULA_OUT,
  input  logic        ULA_CARRY,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic        RSP_ID,
  output logic [7:0]  RSP_DATA,
  output logic        RSP_CARRY,
  output logic [15:0] OP_COUNT
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [1:0]  cond_q, cond_d;
  logic        id_q, id_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic        rsp_id_q, rsp_id_d;

  logic        grant;
  logic        any_req;
  logic [1:0]  ready;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    a_d         = a_q;
    b_d         = b_q;
    cond_d      = cond_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_id_d    = rsp_id_q;

    any_req = |REQ_VALID;
    // A lone request wins outright; a tie goes to req0 (fixed) or to the
    // requester that was not granted last (round-robin).
    if (REQ_VALID == 2'b11) begin
      grant = PRIO_FIXED ? 1'b0 : ~last_q;
    end else begin
      grant = REQ_VALID[1];
    end
    // Ready is gated with RST_N so nothing looks acceptable while in reset.
    if (state_q == S_IDLE && any_req && RST_N) begin
      ready = grant ? 2'b10 : 2'b01;
    end else begin
      ready = 2'b00;
    end

    case (state_q)
      S_IDLE: begin
        if (|(REQ_VALID & ready)) begin
          a_d     = grant ? REQ_A[15:8]   : REQ_A[7:0];
          b_d     = grant ? REQ_B[15:8]   : REQ_B[7:0];
          cond_d  = grant ? REQ_COND[3:2] : REQ_COND[1:0];
          id_d    = grant;
          last_d  = grant;
          cnt_d   = CNT_LOAD;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_data_d  = ULA_OUT;
          rsp_carry_d = ULA_CARRY;
          rsp_id_d    = id_q;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (RSP_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      cond_q      <= 2'd0;
      id_q        <= 1'b0;
      cnt_q       <= 4'd0;
      rsp_data_q  <= 8'd0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cond_q      <= cond_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign REQ_READY = ready;
  assign ULA_A     = a_q;
  assign ULA_B     = b_q;
  assign ULA_COND  = cond_q;
  assign RSP_VALID = (state_q == S_RESP);
  assign RSP_ID    = rsp_id_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_CARRY = rsp_carry_q;

`ifdef ULA_ARB_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (state_q == S_RESP && RSP_READY && op_count_q != 16'hFFFF) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_count_q <= 16'd0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign OP_COUNT = op_count_q;
`else
  assign OP_COUNT = 16'd0;
`endif

endmodule
